// File: rtl/dft_cap_pkg.sv
// Shared sizing, write-FSM state encoding and beat packing for the DFT
// output capture block.
package dft_cap_pkg;

  localparam int unsigned DFT_CAP_FRAME_BEATS = 32;
  localparam int unsigned DFT_CAP_NUM_BUFS    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DROP    = 2'd3
  } cap_state_t;

  typedef logic [63:0] dft_beat_t;

  function automatic dft_beat_t pack_beat(input logic [15:0] y0, input logic [15:0] y1,
                                          input logic [15:0] y2, input logic [15:0] y3);
    return {y3, y2, y1, y0};
  endfunction

endpackage

// File: rtl/dft_cap_frame_buffer.sv
// Frame storage for all buffers: one write port, one read port whose output
// register only updates on a read enable, so it holds steady under stall.
module dft_cap_frame_buffer
  import dft_cap_pkg::*;
#(
  parameter int unsigned DEPTH  = DFT_CAP_NUM_BUFS * DFT_CAP_FRAME_BEATS,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  dft_beat_t         wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output dft_beat_t         rdata_o
);

  dft_beat_t mem_q [DEPTH];
  dft_beat_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dft_output_capture.sv
// Captures DFT output frames into rotating buffers and streams committed
// frames out as valid/ready beats, tracking dropped and restarted frames.
//
//   state   | meaning
//   IDLE    | no frame in flight, waiting for next_out
//   ARM     | writing beat 0 into the claimed buffer
//   CAPTURE | writing beats 1..FRAME_BEATS-1; last beat commits the frame
//   DROP    | no free buffer, letting one frame's beats pass unwritten
module dft_output_capture
  import dft_cap_pkg::*;
#(
  parameter int unsigned FRAME_BEATS = DFT_CAP_FRAME_BEATS,
  parameter int unsigned NUM_BUFS    = DFT_CAP_NUM_BUFS,
  parameter int unsigned DROP_CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      next_out,
  input  logic [15:0]               Y0,
  input  logic [15:0]               Y1,
  input  logic [15:0]               Y2,
  input  logic [15:0]               Y3,
  output logic [63:0]               rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic [$clog2(NUM_BUFS):0] frames_avail,
  output logic                      overflow,
  output logic                      restart_err,
  output logic [DROP_CNT_W-1:0]     drop_count,
  input  logic                      clear_status
);

  localparam int unsigned BW = $clog2(FRAME_BEATS);
  localparam int unsigned PW = $clog2(NUM_BUFS);
  localparam int unsigned AW = PW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  cap_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, wr_beat;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q;
  logic [BW-1:0] rd_beat_q;
  logic [AW-1:0] fa_q, fa_d;
  logic rd_valid_q, rd_last_q;
  logic overflow_q, overflow_d, restart_err_q, restart_err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic wr_en, commit, hs_last, can_claim, fetch_ok, load, drop_ev, restart_ev;

  // A buffer freed by this cycle's last-beat handshake is already claimable.
  assign commit    = (state_q == CAPTURE) && (beat_q == LAST_BEAT);
  assign hs_last   = rd_valid_q & rd_ready & rd_last_q;
  assign fa_d      = fa_q + AW'(commit) - AW'(hs_last);
  assign can_claim = fa_d < AW'(NUM_BUFS);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    wr_beat    = beat_q;
    drop_ev    = 1'b0;
    restart_ev = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (next_out) begin
          state_d = can_claim ? ARM : DROP;
          beat_d  = '0;
          drop_ev = !can_claim;
        end
      end
      ARM: begin
        wr_en   = 1'b1;
        wr_beat = '0;
        beat_d  = BW'(1);
        if (next_out) restart_ev = 1'b1;
        else          state_d    = CAPTURE;
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (beat_q == LAST_BEAT) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          state_d  = IDLE;
          if (next_out) begin
            state_d = can_claim ? ARM : DROP;
            beat_d  = '0;
            drop_ev = !can_claim;
          end
        end else if (next_out) begin
          restart_ev = 1'b1;
          state_d    = ARM;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DROP: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          if (next_out) begin
            state_d = can_claim ? ARM : DROP;
            beat_d  = '0;
            drop_ev = !can_claim;
          end
        end else if (next_out) begin
          beat_d  = '0;
          drop_ev = 1'b1;
        end
      end
    endcase
  end

  // A new drop outranks a same-cycle clear.
  always_comb begin
    overflow_d    = drop_ev ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
    restart_err_d = restart_ev ? 1'b1 : (clear_status ? 1'b0 : restart_err_q);
    drop_cnt_d    = clear_status ? '0 : drop_cnt_q;
    if (drop_ev) begin
      if (clear_status)     drop_cnt_d = DROP_CNT_W'(1);
      else if (&drop_cnt_q) drop_cnt_d = drop_cnt_q;
      else                  drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wr_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      restart_err_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wr_ptr_q      <= wr_ptr_d;
      overflow_q    <= overflow_d;
      restart_err_q <= restart_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A frame whose last beat already sits in the output register is fully
  // fetched; fetch further only if another committed frame is waiting.
  assign fetch_ok = fa_q > AW'(rd_valid_q & rd_last_q);
  assign load     = (!rd_valid_q | rd_ready) & fetch_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q       <= '0;
      rd_ptr_q   <= '0;
      rd_beat_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      fa_q <= fa_d;
      if (load) begin
        rd_valid_q <= 1'b1;
        rd_last_q  <= (rd_beat_q == LAST_BEAT);
        rd_beat_q  <= rd_beat_q + BW'(1);
        if (rd_beat_q == LAST_BEAT) rd_ptr_q <= rd_ptr_q + PW'(1);
      end else if (rd_ready) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  dft_cap_frame_buffer #(
    .DEPTH (NUM_BUFS * FRAME_BEATS),
    .ADDR_W(PW + BW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .waddr_i({wr_ptr_q, wr_beat}),
    .wdata_i(pack_beat(Y0, Y1, Y2, Y3)),
    .re_i   (load),
    .raddr_i({rd_ptr_q, rd_beat_q}),
    .rdata_o(rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign frames_avail = fa_q;
  assign overflow     = overflow_q;
  assign restart_err  = restart_err_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_dft_output_capture.sv
// Directed bench for dft_output_capture: captured beats go to a scoreboard
// queue and are checked in order as the read side hands them out.
module tb_dft_output_capture;
  import dft_cap_pkg::*;

  localparam int FB = DFT_CAP_FRAME_BEATS;
  localparam logic [63:0] IDLE_WORD = 64'h1111_2222_3333_4444;

  logic clk = 1'b0;
  logic rst, next_out, rd_ready, clear_status;
  logic [15:0] Y0, Y1, Y2, Y3;
  logic [63:0] rd_data;
  logic rd_valid, rd_last, overflow, restart_err;
  logic [1:0] frames_avail;
  logic [7:0] drop_count;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  logic [64:0] sb [$];
  logic [64:0] exp_w;
  logic [63:0] prev_data;
  logic prev_last;
  logic prev_stall = 1'b0;

  always #5 clk = ~clk;

  dft_output_capture dut (
    .clk(clk), .rst(rst), .next_out(next_out),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .frames_avail(frames_avail), .overflow(overflow), .restart_err(restart_err),
    .drop_count(drop_count), .clear_status(clear_status)
  );

  function automatic logic [63:0] beat_word(input logic [15:0] tag, input int i);
    logic [15:0] idx;
    idx = 16'(i);
    return {16'hA5A5, tag ^ {idx[7:0], idx[7:0]}, tag, idx};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic nxt, input logic [63:0] y);
    next_out = nxt;
    {Y3, Y2, Y1, Y0} = y;
    case (rdy_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 99) < 30);
    endcase
    @(posedge clk);
    #1;
    next_out = 1'b0;
    clear_status = 1'b0;
  endtask

  task automatic frame(input logic [15:0] tag, input bit push, input bit strobe_first,
                       input bit strobe_last);
    if (strobe_first) cyc(1'b1, IDLE_WORD);
    for (int i = 0; i < FB; i++) begin
      if (push) sb.push_back({1'(i == FB - 1), beat_word(tag, i)});
      cyc(strobe_last && (i == FB - 1), beat_word(tag, i));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(frames_avail == 2'd0 && !rd_valid) && n < budget) begin
      cyc(1'b0, IDLE_WORD);
      n++;
    end
    check({tag, "_drain_in_time"}, 64'(n < budget), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Handshake and stall-stability checks at the falling edge.
  always @(negedge clk) begin
    if (prev_stall && !rst) begin
      check("stall_valid", 64'(rd_valid), 64'd1);
      check("stall_data", rd_data, prev_data);
      check("stall_last", 64'(rd_last), 64'(prev_last));
    end
    if (rd_valid && rd_ready && !rst) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat: observed %0h expected no beat", rd_data);
      end
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("beat_data", rd_data, exp_w[63:0]);
        check("beat_last", 64'(rd_last), 64'(exp_w[64]));
      end
    end
    prev_stall <= rd_valid && !rd_ready && !rst;
    prev_data  <= rd_data;
    prev_last  <= rd_last;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; next_out = 1'b0; clear_status = 1'b0; rd_ready = 1'b0;
    {Y3, Y2, Y1, Y0} = IDLE_WORD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_avail", 64'(frames_avail), 64'd0);
    check("rst_data", rd_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    cyc(1'b0, IDLE_WORD);

    // 1: single frame, free-running consumer
    rdy_mode = 1;
    frame(16'h0001, 1, 1, 0);
    check("t1_avail_up", 64'(frames_avail), 64'd1);
    wait_drain("t1", 200);
    check("t1_avail_down", 64'(frames_avail), 64'd0);

    // 2: back-to-back frames fill both buffers, third frame dropped
    rdy_mode = 0;
    frame(16'h0002, 1, 1, 1);
    frame(16'h0003, 1, 0, 0);
    check("t2_avail2", 64'(frames_avail), 64'd2);
    check("t2_no_overflow", 64'(overflow), 64'd0);
    check("t2_head", rd_data, beat_word(16'h0002, 0));
    frame(16'h0004, 0, 1, 0);
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_drop_count", 64'(drop_count), 64'd1);
    check("t2_avail_kept", 64'(frames_avail), 64'd2);
    clear_status = 1'b1;
    cyc(1'b0, IDLE_WORD);
    check("t2_clear_overflow", 64'(overflow), 64'd0);
    check("t2_clear_drops", 64'(drop_count), 64'd0);

    // 3: drain both frames under random back-pressure
    rdy_mode = 2;
    wait_drain("t3", 2000);

    // 4: restart at beat 10
    rdy_mode = 1;
    cyc(1'b1, IDLE_WORD);
    for (int i = 0; i <= 10; i++) cyc(1'(i == 10), beat_word(16'h0BAD, i));
    frame(16'h0005, 1, 0, 0);
    check("t4_restart_err", 64'(restart_err), 64'd1);
    check("t4_avail1", 64'(frames_avail), 64'd1);
    wait_drain("t4", 200);

    // 5: reset mid-capture with one frame unread
    rdy_mode = 0;
    frame(16'h0006, 1, 1, 0);
    check("t5_avail1", 64'(frames_avail), 64'd1);
    cyc(1'b1, IDLE_WORD);
    for (int i = 0; i < 17; i++) cyc(1'b0, beat_word(16'h0007, i));
    rst = 1'b1;
    cyc(1'b0, beat_word(16'h0007, 17));
    check("t5_data", rd_data, 64'd0);
    check("t5_valid", 64'(rd_valid), 64'd0);
    check("t5_last", 64'(rd_last), 64'd0);
    check("t5_avail", 64'(frames_avail), 64'd0);
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_restart_err", 64'(restart_err), 64'd0);
    check("t5_drop_count", 64'(drop_count), 64'd0);
    sb.delete();
    rst = 1'b0;
    rdy_mode = 1;
    frame(16'h0008, 1, 1, 0);
    wait_drain("t5", 200);

    // 6: last-beat handshake coincides with next_out while both buffers full
    rdy_mode = 0;
    frame(16'h0009, 1, 1, 1);
    frame(16'h000A, 1, 0, 0);
    check("t6_avail2", 64'(frames_avail), 64'd2);
    rdy_mode = 1;
    n = 0;
    while (!(rd_valid && rd_last) && n < 100) begin
      cyc(1'b0, IDLE_WORD);
      n++;
    end
    check("t6_last_in_time", 64'(n < 100), 64'd1);
    cyc(1'b1, IDLE_WORD);
    frame(16'h000B, 1, 0, 0);
    check("t6_drop_count", 64'(drop_count), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    wait_drain("t6", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
